pattern_scan_ctrl: RTL and testbench

Sequencer that drives the pattern datapath's stepped X counter and a row (Y) counter over a rectangular window.
- On start, it latches a window and step mode, then emits (x, y) coordinates as a valid/ready stream.
- X advances by the Xmode step size (0/1/4/8). Y advances by 1 at each row end.
- Signals busy/done to the frame-level control.

---
 rtl/pattern_scan_pkg.sv | 30 +++
 rtl/scan_axis_cnt.sv | 44 ++++
 rtl/pattern_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared types for the pattern scan sequencer: FSM states, X step-mode
// encodings and the step decoder used by the X axis counter.
// No ports; imported by pattern_scan_ctrl and scan_axis_cnt users.
package pattern_scan_pkg;

  // Width of the step value returned by step_of (matches the counter datapath).
  localparam int STEP_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] XMODE_0 = 2'b00;
  localparam logic [1:0] XMODE_1 = 2'b01;
  localparam logic [1:0] XMODE_4 = 2'b10;
  localparam logic [1:0] XMODE_8 = 2'b11;

  function automatic logic [STEP_W-1:0] step_of(input logic [1:0] xmode);
    case (xmode)
      XMODE_1: step_of = STEP_W'(1);
      XMODE_4: step_of = STEP_W'(4);
      XMODE_8: step_of = STEP_W'(8);
      default: step_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/scan_axis_cnt.sv
// Loadable W-bit axis counter that advances by a step and flags when the
// next value would pass an inclusive limit. Load has priority over advance.
// Ports: clk, rst_n, load_i/load_val_i, adv_i, step_i, limit_i -> cnt_o, past_o.
module scan_axis_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         adv_i,
  input  logic [W-1:0] step_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         past_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   nxt;

  // One extra bit so a step past the top of the W-bit range is still seen
  // as beyond the limit rather than wrapping back into the window.
  assign nxt    = {1'b0, cnt_q} + {1'b0, step_i};
  assign past_o = nxt > {1'b0, limit_i};
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (adv_i) begin
      cnt_d = nxt[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Window scan sequencer: emits (x, y) beats over a latched rectangle, X stepping
// by 0/1/4/8 and Y by 1 per row. First beat 2 cycles after start; beats hold
// stable while out_ready is low. Ports: start/stop/config in, out_* stream,
// busy/done/cfg_err status. Optional PATTERN_SCAN_BEAT_CNT_EN adds beat_cnt.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int W     = 12,
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   xmode,
  input  logic [W-1:0] x_start,
  input  logic [W-1:0] x_end,
  input  logic [W-1:0] y_start,
  input  logic [W-1:0] y_end,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic         line_end,
  output logic         busy,
  output logic         done,
  output logic         cfg_err
`ifdef PATTERN_SCAN_BEAT_CNT_EN
  ,
  output logic [2*W-1:0] beat_cnt
`endif
);

  localparam logic [W-1:0] X_MAX_W = W'(X_MAX);
  localparam logic [W-1:0] Y_MAX_W = W'(Y_MAX);

  state_t       state_q, state_d;
  logic         valid_q, valid_d;
  logic         cfg_err_q, cfg_err_d;
  logic [1:0]   xmode_q;
  logic [W-1:0] xs_q, xe_q, ys_q, ye_q;
  logic         latch;
  logic         x_load, x_adv, y_load, y_adv;
  logic         x_past, y_past;
  logic [W-1:0] step;
  logic         cfg_bad, xfer, row_end;

  assign step    = W'(step_of(xmode_q));
  assign cfg_bad = (x_start > x_end) || (y_start > y_end) ||
                   (x_end > X_MAX_W) || (y_end > Y_MAX_W);
  assign xfer    = valid_q && out_ready;
  // A zero step never moves along the row, so every beat closes its row.
  assign row_end = (step == '0) || x_past;

  assign out_valid = valid_q;
  assign line_end  = valid_q && row_end;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign cfg_err   = cfg_err_q;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    cfg_err_d = 1'b0;
    latch     = 1'b0;
    x_load    = 1'b0;
    x_adv     = 1'b0;
    y_load    = 1'b0;
    y_adv     = 1'b0;
    if (stop) begin
      // Abort from anywhere; counters hold and no done pulse follows.
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_d = 1'b1;
            end else begin
              latch   = 1'b1;
              state_d = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          x_load  = 1'b1;
          y_load  = 1'b1;
          valid_d = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (xfer) begin
            if (!row_end) begin
              x_adv = 1'b1;
            end else if (!y_past) begin
              x_load = 1'b1;
              y_adv  = 1'b1;
            end else begin
              valid_d = 1'b0;
              state_d = ST_DONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      xmode_q   <= XMODE_0;
      xs_q      <= '0;
      xe_q      <= '0;
      ys_q      <= '0;
      ye_q      <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      cfg_err_q <= cfg_err_d;
      if (latch) begin
        xmode_q <= xmode;
        xs_q    <= x_start;
        xe_q    <= x_end;
        ys_q    <= y_start;
        ye_q    <= y_end;
      end
    end
  end

  // Y has step 1, so "next passes the limit" is exactly "on the last row".
  scan_axis_cnt #(.W(W)) u_x_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (x_load),
    .load_val_i (xs_q),
    .adv_i      (x_adv),
    .step_i     (step),
    .limit_i    (xe_q),
    .cnt_o      (x_out),
    .past_o     (x_past)
  );

  scan_axis_cnt #(.W(W)) u_y_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (y_load),
    .load_val_i (ys_q),
    .adv_i      (y_adv),
    .step_i     (W'(1)),
    .limit_i    (ye_q),
    .cnt_o      (y_out),
    .past_o     (y_past)
  );

`ifdef PATTERN_SCAN_BEAT_CNT_EN
  logic [2*W-1:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (state_q == ST_LOAD) begin
      beat_cnt_q <= '0;
    end else if (xfer) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
module tb_pattern_scan_ctrl;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop, out_ready;
  logic [1:0]   xmode;
  logic [W-1:0] x_start, x_end, y_start, y_end;
  logic         out_valid, line_end, busy, done, cfg_err;
  logic [W-1:0] x_out, y_out;
`ifdef PATTERN_SCAN_BEAT_CNT_EN
  logic [2*W-1:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.W(W), .X_MAX(639), .Y_MAX(479)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .xmode     (xmode),
    .x_start   (x_start),
    .x_end     (x_end),
    .y_start   (y_start),
    .y_end     (y_end),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .x_out     (x_out),
    .y_out     (y_out),
    .line_end  (line_end),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
`ifdef PATTERN_SCAN_BEAT_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  typedef struct {
    int x;
    int y;
    int le;
  } beat_t;

  typedef struct {
    int       xs, xe, ys, ye;
    int       mode;
    int       first;
    int       n;
    bit       bp;
  } case_t;

  typedef struct {
    int xs, xe, ys, ye;
    bit with_stop;
    int exp_err;
  } err_t;

  beat_t eb[$];
  case_t cases[$];
  err_t  errs[$];

  int checks   = 0;
  int failures = 0;
  logic [3:0] bp_pat = 4'b1001;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int xs, input int xe, input int ys, input int ye, input int mode);
    x_start = W'(xs);
    x_end   = W'(xe);
    y_start = W'(ys);
    y_end   = W'(ye);
    xmode   = 2'(mode);
  endtask

  task automatic run_scan(input case_t c, input bit poke);
    int    got;
    int    k;
    bit    seen_done;
    bit    held;
    int    hx, hy, hl;
    beat_t e;
    @(negedge clk);
    set_cfg(c.xs, c.xe, c.ys, c.ye, c.mode);
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", int'(busy), 1);
    chk("load_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("first_beat_latency", int'(out_valid), 1);
    got = 0; k = 0; seen_done = 0; held = 0; hx = 0; hy = 0; hl = 0;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start     = 1'b0;
      out_ready = c.bp ? bp_pat[k % 4] : 1'b1;
      k++;
      if (held && out_valid) begin
        chk("hold_x", int'(x_out), hx);
        chk("hold_y", int'(y_out), hy);
        chk("hold_le", int'(line_end), hl);
      end
      if (done) begin
        seen_done = 1;
        chk("done_valid_low", int'(out_valid), 0);
        chk("done_busy_low", int'(busy), 0);
      end else if (out_valid && out_ready) begin
        if (got < c.n) begin
          e = eb[c.first + got];
          chk("beat_x", int'(x_out), e.x);
          chk("beat_y", int'(y_out), e.y);
          chk("beat_le", int'(line_end), e.le);
        end
        got++;
        held = 0;
        if (poke && got == 2) begin
          // Busy: this start and the changed config must be ignored.
          start = 1'b1;
          set_cfg(1, 2, 1, 1, 1);
        end
      end else if (out_valid) begin
        held = 1;
        hx = int'(x_out); hy = int'(y_out); hl = int'(line_end);
      end
    end
    chk("done_seen", int'(seen_done), 1);
    chk("beat_count", got, c.n);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_not_busy", int'(busy), 0);
  endtask

  initial begin
    case_t c;
    int    b;
    // Expected beats, hand-computed.
    // case 0: x 0..8 step 4, y 0..1
    eb.push_back('{0,0,0}); eb.push_back('{4,0,0}); eb.push_back('{8,0,1});
    eb.push_back('{0,1,0}); eb.push_back('{4,1,0}); eb.push_back('{8,1,1});
    // case 1: x 5..12 step 8, y 3 -> 13 > 12 so single beat
    eb.push_back('{5,3,1});
    // case 2: step 0, x 7..20, y 0..2
    eb.push_back('{7,0,1}); eb.push_back('{7,1,1}); eb.push_back('{7,2,1});
    // case 3: x 0..3 step 1 with backpressure
    eb.push_back('{0,0,0}); eb.push_back('{1,0,0}); eb.push_back('{2,0,0}); eb.push_back('{3,0,1});
    // case 4: single pixel
    eb.push_back('{9,4,1});
    // case 5: right/bottom legal edge, step 1
    eb.push_back('{638,479,0}); eb.push_back('{639,479,1});
    // case 6: right edge with step 8 past X_MAX
    eb.push_back('{636,479,1});

    cases.push_back('{0,   8,   0,   1,   2, 0,  6, 1'b0});
    cases.push_back('{5,   12,  3,   3,   3, 6,  1, 1'b0});
    cases.push_back('{7,   20,  0,   2,   0, 7,  3, 1'b0});
    cases.push_back('{0,   3,   0,   0,   1, 10, 4, 1'b1});
    cases.push_back('{9,   9,   4,   4,   1, 14, 1, 1'b0});
    cases.push_back('{638, 639, 479, 479, 1, 15, 2, 1'b0});
    cases.push_back('{636, 639, 479, 479, 3, 17, 1, 1'b0});

    errs.push_back('{10, 9,   0, 0,   1'b0, 1});
    errs.push_back('{0,  0,   0, 480, 1'b0, 1});
    errs.push_back('{0,  640, 0, 0,   1'b0, 1});
    errs.push_back('{0,  0,   5, 4,   1'b0, 1});
    errs.push_back('{10, 9,   0, 0,   1'b1, 0});
    errs.push_back('{0,  3,   0, 3,   1'b1, 0});

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_line_end", int'(line_end), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_y", int'(y_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (cases[i]) run_scan(cases[i], 1'b0);

    // Start while busy is ignored: same beats as case 0.
    run_scan(cases[0], 1'b1);

    // Rejected configurations and stop-beats-start in IDLE.
    foreach (errs[i]) begin
      @(negedge clk);
      set_cfg(errs[i].xs, errs[i].xe, errs[i].ys, errs[i].ye, 1);
      start = 1'b1;
      stop  = errs[i].with_stop;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err), errs[i].exp_err);
      chk("cfg_err_busy", int'(busy), 0);
      @(negedge clk);
      chk("cfg_err_clear", int'(cfg_err), 0);
      chk("cfg_err_idle", int'(busy), 0);
    end

    // Stop on the third beat of a 4x4 scan.
    @(negedge clk);
    set_cfg(0, 3, 0, 3, 1);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (out_valid && b == 2) break;
      if (out_valid) b++;
    end
    chk("stop_at_third_x", int'(x_out), 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_valid", int'(out_valid), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_x_hold", int'(x_out), 2);
    chk("stop_y_hold", int'(y_out), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stop_no_done", int'(done), 0);
    end

    // Rescan the same window from its origin.
    c.xs = 0; c.xe = 3; c.ys = 0; c.ye = 3; c.mode = 1; c.bp = 1'b0;
    c.first = eb.size(); c.n = 16;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        eb.push_back('{x, y, (x == 3) ? 1 : 0});
    run_scan(c, 1'b0);

    // Asynchronous reset mid-scan.
    @(negedge clk);
    set_cfg(0, 8, 0, 1, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_x", int'(x_out), 0);
    chk("arst_y", int'(y_out), 0);
    chk("arst_line_end", int'(line_end), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
